// File: rtl/e1_sequence_monitor.sv
// e1_sequence_monitor
//   Consumes the E1 stream (first=1, second=2, third=3, 0 illegal) through a
//   single registered valid/ready stage. It also:
//   - checks for the ordered sequence first -> second -> third;
//   - pulses seq_done / seq_error for one cycle after the causing transfer;
//   - keeps saturating per-code occurrence counters.
//   Illegal codes are accepted and counted, but never forwarded.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake, in_data is the 2-bit E1 code
//   out_valid/out_ready downstream handshake, out_data is the registered code
//   clr_counts          clears counters and error_sticky (wins over counting)
//   seq_done/seq_error  registered one-cycle status pulses
//   error_sticky        set by any seq_error, cleared by rst or clr_counts
//   cnt_*               saturating occurrence counters, CNT_WIDTH bits each
module e1_sequence_monitor #(
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [1:0]           out_data,
    input  logic                 clr_counts,
    output logic                 seq_done,
    output logic                 seq_error,
    output logic                 error_sticky,
    output logic [CNT_WIDTH-1:0] cnt_first,
    output logic [CNT_WIDTH-1:0] cnt_second,
    output logic [CNT_WIDTH-1:0] cnt_third,
    output logic [CNT_WIDTH-1:0] cnt_illegal
);

    typedef enum logic [1:0] {
        StIdle,
        StGotFirst,
        StGotSecond
    } state_e;

    localparam logic [1:0] CodeIllegal = 2'd0;
    localparam logic [1:0] CodeFirst   = 2'd1;
    localparam logic [1:0] CodeSecond  = 2'd2;
    localparam logic [1:0] CodeThird   = 2'd3;

    localparam logic [CNT_WIDTH-1:0] CntMax = '1;
    localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

    state_e                 state_q, state_d;
    logic                   out_valid_q, out_valid_d;
    logic [1:0]             out_data_q, out_data_d;
    logic                   seq_done_q, seq_done_d;
    logic                   seq_error_q, seq_error_d;
    logic                   error_sticky_q, error_sticky_d;
    logic [CNT_WIDTH-1:0]   cnt_first_q, cnt_first_d;
    logic [CNT_WIDTH-1:0]   cnt_second_q, cnt_second_d;
    logic [CNT_WIDTH-1:0]   cnt_third_q, cnt_third_d;
    logic [CNT_WIDTH-1:0]   cnt_illegal_q, cnt_illegal_d;

    logic xfer;
    logic legal;

    // Ready whenever the stage is empty or being drained this cycle.
    assign in_ready = !out_valid_q || out_ready;
    assign xfer     = in_valid && in_ready;
    assign legal    = (in_data != CodeIllegal);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CntMax) ? v : v + CntOne;
    endfunction

    always_comb begin
        state_d        = state_q;
        out_valid_d    = out_valid_q;
        out_data_d     = out_data_q;
        seq_done_d     = 1'b0;
        seq_error_d    = 1'b0;
        error_sticky_d = error_sticky_q;
        cnt_first_d    = cnt_first_q;
        cnt_second_d   = cnt_second_q;
        cnt_third_d    = cnt_third_q;
        cnt_illegal_d  = cnt_illegal_q;

        // Pipeline stage. An illegal xfer only happens while in_ready, so the
        // drain branch already covers "accepted but not forwarded".
        if (xfer && legal) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        // Sequence checker, advances only on a transfer.
        if (xfer) begin
            unique case (state_q)
                StIdle: begin
                    case (in_data)
                        CodeFirst:   state_d = StGotFirst;
                        CodeIllegal: seq_error_d = 1'b1;
                        default:     state_d = StIdle;
                    endcase
                end
                StGotFirst: begin
                    case (in_data)
                        CodeFirst:  state_d = StGotFirst;
                        CodeSecond: state_d = StGotSecond;
                        default: begin
                            state_d     = StIdle;
                            seq_error_d = 1'b1;
                        end
                    endcase
                end
                StGotSecond: begin
                    case (in_data)
                        CodeThird: begin
                            state_d    = StIdle;
                            seq_done_d = 1'b1;
                        end
                        CodeFirst: begin
                            // A new first still starts a fresh sequence.
                            state_d     = StGotFirst;
                            seq_error_d = 1'b1;
                        end
                        default: begin
                            state_d     = StIdle;
                            seq_error_d = 1'b1;
                        end
                    endcase
                end
                default: state_d = StIdle;
            endcase
        end

        // Clear has priority over both counting and setting the sticky flag.
        if (clr_counts) begin
            error_sticky_d = 1'b0;
            cnt_first_d    = '0;
            cnt_second_d   = '0;
            cnt_third_d    = '0;
            cnt_illegal_d  = '0;
        end else begin
            if (seq_error_d) begin
                error_sticky_d = 1'b1;
            end
            if (xfer) begin
                case (in_data)
                    CodeFirst:  cnt_first_d   = sat_inc(cnt_first_q);
                    CodeSecond: cnt_second_d  = sat_inc(cnt_second_q);
                    CodeThird:  cnt_third_d   = sat_inc(cnt_third_q);
                    default:    cnt_illegal_d = sat_inc(cnt_illegal_q);
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            out_valid_q    <= 1'b0;
            out_data_q     <= CodeFirst;
            seq_done_q     <= 1'b0;
            seq_error_q    <= 1'b0;
            error_sticky_q <= 1'b0;
            cnt_first_q    <= '0;
            cnt_second_q   <= '0;
            cnt_third_q    <= '0;
            cnt_illegal_q  <= '0;
        end else begin
            state_q        <= state_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            seq_done_q     <= seq_done_d;
            seq_error_q    <= seq_error_d;
            error_sticky_q <= error_sticky_d;
            cnt_first_q    <= cnt_first_d;
            cnt_second_q   <= cnt_second_d;
            cnt_third_q    <= cnt_third_d;
            cnt_illegal_q  <= cnt_illegal_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign seq_done     = seq_done_q;
    assign seq_error    = seq_error_q;
    assign error_sticky = error_sticky_q;
    assign cnt_first    = cnt_first_q;
    assign cnt_second   = cnt_second_q;
    assign cnt_third    = cnt_third_q;
    assign cnt_illegal  = cnt_illegal_q;

endmodule

// File: tb/tb_e1_sequence_monitor.sv
// Scoreboard bench for e1_sequence_monitor (CNT_WIDTH=2 so saturation is reachable).
// Stimulus pushes expected forwarded codes and expected status pulses into
// queues; a negedge monitor pops and compares whenever the DUT presents them.
module tb_e1_sequence_monitor;

    localparam int unsigned W = 2;
    localparam logic [1:0] PNone = 2'b00;
    localparam logic [1:0] PDone = 2'b10;  // {seq_done, seq_error}
    localparam logic [1:0] PErr  = 2'b01;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   in_data = 2'd0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [1:0]   out_data;
    logic         clr_counts = 1'b0;
    logic         seq_done;
    logic         seq_error;
    logic         error_sticky;
    logic [W-1:0] cnt_first;
    logic [W-1:0] cnt_second;
    logic [W-1:0] cnt_third;
    logic [W-1:0] cnt_illegal;

    int checks   = 0;
    int failures = 0;

    logic [1:0] exp_data[$];
    logic [1:0] exp_pulse[$];

    e1_sequence_monitor #(.CNT_WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .clr_counts   (clr_counts),
        .seq_done     (seq_done),
        .seq_error    (seq_error),
        .error_sticky (error_sticky),
        .cnt_first    (cnt_first),
        .cnt_second   (cnt_second),
        .cnt_third    (cnt_third),
        .cnt_illegal  (cnt_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare forwarded codes and status pulses against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (exp_data.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL out_data_unexpected: got %0d expected none (t=%0t)",
                             out_data, $time);
                end else begin
                    chk("out_data", int'(out_data), int'(exp_data.pop_front()));
                end
            end
            if (seq_done || seq_error) begin
                if (exp_pulse.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pulse_unexpected: got done=%0d err=%0d expected none (t=%0t)",
                             seq_done, seq_error, $time);
                end else begin
                    chk("pulse{done,err}", int'({seq_done, seq_error}),
                        int'(exp_pulse.pop_front()));
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [1:0] d, input logic ordy, input logic clr,
                        input logic [1:0] pulse);
        int n = 0;
        bit took = 0;
        in_valid   = 1'b1;
        in_data    = d;
        out_ready  = ordy;
        clr_counts = clr;
        while (!took && n < 20) begin
            #2;
            if (in_ready) begin
                took = 1;
                if (d != 2'd0) exp_data.push_back(d);
                if (pulse != PNone) exp_pulse.push_back(pulse);
            end
            @(posedge clk);
            #1;
            n++;
        end
        in_valid   = 1'b0;
        clr_counts = 1'b0;
        if (!took) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got no in_ready expected accept of %0d", d);
        end
    endtask

    task automatic idle(input int n, input logic ordy);
        in_valid  = 1'b0;
        out_ready = ordy;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset values
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 1);
        chk("rst_seq_done", int'(seq_done), 0);
        chk("rst_seq_error", int'(seq_error), 0);
        chk("rst_sticky", int'(error_sticky), 0);
        chk("rst_cnt_first", int'(cnt_first), 0);
        chk("rst_cnt_illegal", int'(cnt_illegal), 0);

        // Ordered stream 1,2,3 with one-cycle latency
        send(2'd1, 1'b1, 1'b0, PNone);
        chk("lat_valid_1", int'(out_valid), 1);
        chk("lat_data_1", int'(out_data), 1);
        send(2'd2, 1'b1, 1'b0, PNone);
        chk("lat_data_2", int'(out_data), 2);
        send(2'd3, 1'b1, 1'b0, PDone);
        chk("lat_data_3", int'(out_data), 3);
        idle(2, 1'b1);
        chk("ord_cnt_first", int'(cnt_first), 1);
        chk("ord_cnt_second", int'(cnt_second), 1);
        chk("ord_cnt_third", int'(cnt_third), 1);
        chk("ord_sticky", int'(error_sticky), 0);

        // Ordering errors: 1,3 then 1,2,1 then 2,3
        send(2'd1, 1'b1, 1'b0, PNone);
        send(2'd3, 1'b1, 1'b0, PErr);
        idle(1, 1'b1);
        chk("err_sticky", int'(error_sticky), 1);
        send(2'd1, 1'b1, 1'b0, PNone);
        send(2'd2, 1'b1, 1'b0, PNone);
        send(2'd1, 1'b1, 1'b0, PErr);
        send(2'd2, 1'b1, 1'b0, PNone);
        send(2'd3, 1'b1, 1'b0, PDone);
        idle(2, 1'b1);
        chk("err_cnt_third_sat", int'(cnt_third), 3);

        // Illegal code: 1,0,2 forwards only 1,2; trailing 2 gives no done
        send(2'd1, 1'b1, 1'b0, PNone);
        send(2'd0, 1'b1, 1'b0, PErr);
        send(2'd2, 1'b1, 1'b0, PNone);
        idle(2, 1'b1);
        chk("ill_cnt_illegal", int'(cnt_illegal), 1);

        // Backpressure: 1 taken, 2 stalls until out_ready pulses high
        send(2'd1, 1'b0, 1'b0, PNone);
        in_valid  = 1'b1;
        in_data   = 2'd2;
        out_ready = 1'b0;
        repeat (3) begin
            #2;
            chk("bp_in_ready_low", int'(in_ready), 0);
            chk("bp_hold_data", int'(out_data), 1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #2;
        chk("bp_in_ready_high", int'(in_ready), 1);
        if (in_ready) exp_data.push_back(2'd2);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        chk("bp_next_data", int'(out_data), 2);
        chk("bp_next_valid", int'(out_valid), 1);
        @(posedge clk);
        #1;
        idle(2, 1'b1);

        // Saturation: FSM is in GOT_SECOND, so the first '1' is an error
        send(2'd1, 1'b1, 1'b0, PErr);
        repeat (4) send(2'd1, 1'b1, 1'b0, PNone);
        chk("sat_cnt_first", int'(cnt_first), 3);
        chk("sat_sticky", int'(error_sticky), 1);
        send(2'd1, 1'b1, 1'b1, PNone);
        chk("clr_cnt_first", int'(cnt_first), 0);
        chk("clr_sticky", int'(error_sticky), 0);
        chk("clr_cnt_third", int'(cnt_third), 0);
        send(2'd2, 1'b1, 1'b0, PNone);
        send(2'd3, 1'b1, 1'b0, PDone);
        idle(1, 1'b1);
        chk("clr_cnt_second", int'(cnt_second), 1);
        // Clear with an illegal xfer: pulse still fires, sticky stays clear
        send(2'd0, 1'b1, 1'b1, PErr);
        idle(1, 1'b1);
        chk("clr_err_sticky", int'(error_sticky), 0);
        chk("clr_err_cnt_illegal", int'(cnt_illegal), 0);

        // Reset mid-operation in GOT_SECOND holding out_data=2
        send(2'd1, 1'b1, 1'b0, PNone);
        send(2'd2, 1'b1, 1'b0, PNone);
        idle(1, 1'b0);
        chk("mid_hold_valid", int'(out_valid), 1);
        rst = 1'b1;
        exp_data.delete();
        exp_pulse.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_cnt_first", int'(cnt_first), 0);
        chk("mid_rst_cnt_second", int'(cnt_second), 0);
        send(2'd3, 1'b1, 1'b0, PNone);
        idle(3, 1'b1);
        chk("mid_cnt_third", int'(cnt_third), 1);
        chk("mid_sticky", int'(error_sticky), 0);

        chk("data_q_empty", exp_data.size(), 0);
        chk("pulse_q_empty", exp_pulse.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/e1_sequence_monitor.md
Name: e1_sequence_monitor

Overview:
Stage downstream of the E1 pass-through `top` block; it consumes the E1 stream that `top` produces (`out_a`).
- Registers accepted E1 values into a single valid/ready pipeline stage for the next consumer.
- Checks that values arrive in the order first -> second -> third, and reports completion and ordering errors.
- Keeps saturating per-value occurrence counters and drops illegal encodings.

Parameters:
CNT_WIDTH, 8, width of each occurrence counter

Ports:
clk  input  1  clock, all logic rising-edge
rst  input  1  synchronous active-high reset
in_valid  input  1  upstream value valid
in_ready  output  1  this block can accept a value
in_data  input  2  E1 value (first=1, second=2, third=3; code 0 illegal)
out_valid  output  1  registered value valid
out_ready  input  1  downstream accepts
out_data  output  2  registered E1 value
clr_counts  input  1  clear counters and sticky error
seq_done  output  1  one-cycle pulse: first, second, third completed in order
seq_error  output  1  one-cycle pulse: ordering violation or illegal code
error_sticky  output  1  set by any seq_error, cleared by rst/clr_counts
cnt_first  output  CNT_WIDTH  accepted count of first
cnt_second  output  CNT_WIDTH  accepted count of second
cnt_third  output  CNT_WIDTH  accepted count of third
cnt_illegal  output  CNT_WIDTH  accepted count of code 0

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: out_valid=0, out_data=first (2'd1), FSM=IDLE, all counters=0, seq_done=0, seq_error=0, error_sticky=0.
- Transfer: an input transfer ("xfer") occurs when in_valid && in_ready.
- in_ready = !out_valid || out_ready. This is combinational, so the stage sustains one transfer per cycle with no bubbles.
- Pipeline stage, on an xfer of a legal code:
  - out_data <= in_data and out_valid <= 1 on the next edge; latency is 1 cycle.
- Pipeline stage, on an xfer of an illegal code (0):
  - The value is accepted but not forwarded.
  - out_valid <= 0 if out_ready was high; otherwise the held output is unchanged.
- Output drain: if out_valid && out_ready and there is no legal xfer, out_valid <= 0.
- Output hold: while out_valid && !out_ready, out_data is stable.
- FSM: states IDLE, GOT_FIRST, GOT_SECOND. It advances only on an xfer.
  - IDLE:
    - first -> GOT_FIRST.
    - second/third -> IDLE, no error.
    - illegal -> IDLE + seq_error.
  - GOT_FIRST:
    - second -> GOT_SECOND.
    - first -> GOT_FIRST (restart, no error).
    - third/illegal -> IDLE + seq_error.
  - GOT_SECOND:
    - third -> IDLE + seq_done.
    - first -> GOT_FIRST + seq_error.
    - second/illegal -> IDLE + seq_error.
- Pulses: seq_done and seq_error are registered. Each is high for exactly the one cycle after the causing xfer; they are never both high.
- error_sticky: set on the same edge that asserts seq_error; holds until rst or clr_counts.
- Counters: each increments by 1 on an xfer of its code and saturates at 2^CNT_WIDTH-1 (no wrap).
- clr_counts in the same cycle as an xfer: the clear wins.
  - Counters and error_sticky go to 0; that xfer is not counted.
  - That xfer still drives the FSM, pulses and pipeline.
  - If it produces seq_error, error_sticky is 0 after the clear (clear priority).
- Reset mid-operation: all state returns to reset values on the next edge. A held out_data is discarded.

Test Plan:
- Ordered stream: after rst, stream 1,2,3 with out_ready=1 -> out_data 1,2,3 on consecutive cycles, each 1 cycle late; seq_done high one cycle after the '3' xfer; cnt_first=cnt_second=cnt_third=1; seq_error never high.
- Ordering errors: stream 1,3 -> seq_error pulse after the '3', error_sticky=1, FSM IDLE. Then stream 1,2,1 -> seq_error after the second '1', and a following 2,3 gives seq_done.
- Illegal code: stream 1,0,2 -> out_data carries only 1,2; cnt_illegal=1; seq_error after the '0'; a subsequent '2' does not produce seq_done.
- Backpressure: out_ready=0 while sending 1,2 -> in_ready drops after the first xfer and out_data holds 1. out_ready=1 for one cycle -> 2 accepted in that same cycle, no loss or duplication.
- Saturation and clear: with CNT_WIDTH=2, send first x5 -> cnt_first=3. Assert clr_counts with a '1' xfer -> cnt_first=0 and error_sticky=0 next cycle, and the FSM is in GOT_FIRST.
- Reset mid-operation: rst asserted in GOT_SECOND with out_valid=1 -> next cycle out_valid=0, all counters 0. A subsequent '3' gives no seq_done and no seq_error.
